// File: rtl/fdau_frame_builder.sv
// Double-buffered FDAU frame assembler: ADC samples, counter words and digital channel words into a 2-bank RAM.
// Optional FDAU_FRAME_CRC_EN appends a DW-bit additive checksum word at address FRAME_LEN.
module fdau_frame_builder #(
    parameter int DW         = 16,
    parameter int N_ADC      = 65,
    parameter int N_CNT      = 3,
    parameter int N_DIGI     = 6,
    parameter int DIGI_DEPTH = 32,
    parameter int AW         = 9,
    localparam int DIGI_AW   = $clog2(DIGI_DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sec,
    input  logic                   sample_rdy,
    input  logic [DW-1:0]          ADC_sample,
    input  logic [N_CNT*DW-1:0]    cnt_words,
    input  logic [N_DIGI*DW-1:0]   digi_data,
    output logic [DIGI_AW-1:0]     digi_rd,
    input  logic [AW-1:0]          rd_fdau,
    output logic [DW-1:0]          q_fdau,
    output logic                   rd_bank,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int FRAME_LEN = N_ADC + N_CNT + N_DIGI * DIGI_DEPTH;
`ifdef FDAU_FRAME_CRC_EN
    localparam int LAST_ADDR = FRAME_LEN;
`else
    localparam int LAST_ADDR = FRAME_LEN - 1;
`endif
    localparam int CW  = (N_CNT > 1) ? $clog2(N_CNT) : 1;
    localparam int CHW = (N_DIGI > 1) ? $clog2(N_DIGI) : 1;

    localparam logic [AW-1:0]      ADDR_MAX  = AW'(LAST_ADDR);
    localparam logic [AW-1:0]      ADC_LAST  = AW'(N_ADC - 1);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(N_CNT - 1);
    localparam logic [CHW-1:0]     CHAN_LAST = CHW'(N_DIGI - 1);
    localparam logic [DIGI_AW-1:0] DIGI_LAST = DIGI_AW'(DIGI_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADC_WAIT,
        CNT,
        DIGI_ADDR,
        DIGI_CAP,
`ifdef FDAU_FRAME_CRC_EN
        CRC_SUM,
`endif
        FINISH
    } state_t;

    state_t          state;
    logic            wr_bank;
    logic [AW-1:0]   wr_addr;
    logic [CW-1:0]   cnt_sel;
    logic [CHW-1:0]  chan;
    logic            rdy_prev;
    logic            wr_en;
    logic [AW:0]     wr_ptr;
    logic [DW-1:0]   wr_data;
    logic            take;
    logic [DW-1:0]   take_data;
`ifdef FDAU_FRAME_CRC_EN
    logic [DW-1:0]   crc_sum;
`endif

    logic [DW-1:0] mem [0:(2**(AW+1))-1];

    assign rd_bank = ~wr_bank;

    // Word the current state wants to store this clock, if any.
    always_comb begin
        take      = 1'b0;
        take_data = '0;
        case (state)
            ADC_WAIT: begin
                take      = sample_rdy && !rdy_prev;
                take_data = ADC_sample;
            end
            CNT: begin
                take      = 1'b1;
                take_data = cnt_words[int'(cnt_sel) * DW +: DW];
            end
            DIGI_CAP: begin
                take      = 1'b1;
                take_data = digi_data[int'(chan) * DW +: DW];
            end
`ifdef FDAU_FRAME_CRC_EN
            CRC_SUM: begin
                take      = 1'b1;
                take_data = crc_sum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            cnt_sel    <= '0;
            chan       <= '0;
            digi_rd    <= '0;
            rdy_prev   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            wr_en      <= 1'b0;
            wr_ptr     <= '0;
            wr_data    <= '0;
`ifdef FDAU_FRAME_CRC_EN
            crc_sum    <= '0;
`endif
        end else begin
            rdy_prev   <= sample_rdy;
            frame_done <= 1'b0;
            wr_en      <= take && !sec;
            wr_ptr     <= {wr_bank, wr_addr};
            wr_data    <= take_data;

            if (take && !sec) begin
                if (wr_addr < ADDR_MAX)
                    wr_addr <= wr_addr + AW'(1);
`ifdef FDAU_FRAME_CRC_EN
                crc_sum <= crc_sum + take_data;
`endif
            end

            if (state == FINISH) begin
                frame_done <= 1'b1;
                wr_bank    <= ~wr_bank;
            end

            // sec always (re)starts a frame; only mid-frame arrivals count as overrun.
            if (sec) begin
                if (state != IDLE && state != FINISH)
                    overrun <= 1'b1;
                state   <= ADC_WAIT;
                wr_addr <= '0;
                cnt_sel <= '0;
                chan    <= '0;
                digi_rd <= '0;
`ifdef FDAU_FRAME_CRC_EN
                crc_sum <= '0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    ADC_WAIT: begin
                        if (take && wr_addr == ADC_LAST)
                            state <= CNT;
                    end
                    CNT: begin
                        if (cnt_sel == CNT_LAST) begin
                            state   <= DIGI_ADDR;
                            chan    <= '0;
                            digi_rd <= '0;
                        end else begin
                            cnt_sel <= cnt_sel + CW'(1);
                        end
                    end
                    DIGI_ADDR: state <= DIGI_CAP;
                    DIGI_CAP: begin
                        state <= DIGI_ADDR;
                        if (digi_rd == DIGI_LAST) begin
                            digi_rd <= '0;
                            if (chan == CHAN_LAST) begin
`ifdef FDAU_FRAME_CRC_EN
                                state <= CRC_SUM;
`else
                                state <= FINISH;
`endif
                            end else begin
                                chan <= chan + CHW'(1);
                            end
                        end else begin
                            digi_rd <= digi_rd + DIGI_AW'(1);
                        end
                    end
`ifdef FDAU_FRAME_CRC_EN
                    CRC_SUM: state <= FINISH;
`endif
                    FINISH: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Writes are registered one clock behind the FSM so the last word lands on the FINISH edge.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            q_fdau <= '0;
        else
            q_fdau <= mem[{~wr_bank, rd_fdau}];
    end

endmodule

// File: tb/tb_fdau_frame_builder.sv
// Self-checking bench for fdau_frame_builder: frame-level model plus directed literal checks.
// Build with FDAU_FRAME_CRC_EN defined to also check the checksum word.
module tb_fdau_frame_builder;

    localparam int DW        = 16;
    localparam int N_ADC     = 65;
    localparam int N_CNT     = 3;
    localparam int N_DIGI    = 6;
    localparam int DEPTH     = 32;
    localparam int AW        = 9;
    localparam int FRAME_LEN = N_ADC + N_CNT + N_DIGI * DEPTH;
`ifdef FDAU_FRAME_CRC_EN
    localparam int TAIL = N_CNT + 2 * N_DIGI * DEPTH + 1;
`else
    localparam int TAIL = N_CNT + 2 * N_DIGI * DEPTH;
`endif

    logic                  clock;
    logic                  reset;
    logic                  sec;
    logic                  sample_rdy;
    logic [DW-1:0]         ADC_sample;
    logic [N_CNT*DW-1:0]   cnt_words;
    logic [N_DIGI*DW-1:0]  digi_data;
    logic [4:0]            digi_rd;
    logic [AW-1:0]         rd_fdau;
    logic [DW-1:0]         q_fdau;
    logic                  rd_bank;
    logic                  frame_done;
    logic                  overrun;

    int compared   = 0;
    int mismatched = 0;
    int done_count = 0;
    bit digi_mode  = 0;

    fdau_frame_builder dut (
        .clock      (clock),
        .reset      (reset),
        .sec        (sec),
        .sample_rdy (sample_rdy),
        .ADC_sample (ADC_sample),
        .cnt_words  (cnt_words),
        .digi_data  (digi_data),
        .digi_rd    (digi_rd),
        .rd_fdau    (rd_fdau),
        .q_fdau     (q_fdau),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] digi_val(input int k, input int j);
        if (digi_mode)
            return 16'h0001;
        return 16'(k * 256 + j);
    endfunction

    // Digital channel RAMs with one clock of read latency.
    always @(posedge clock) begin
        for (int k = 0; k < N_DIGI; k++)
            digi_data[k*DW +: DW] <= digi_val(k, int'(digi_rd));
    end

    // Frame-level model: 0 idle, 1 collecting ADC, 2 fixed-length tail, 3 finishing.
    logic [DW-1:0] m_mem [0:1][0:511];
    bit            m_valid [0:1][0:511];
    logic [DW-1:0] m_img [0:511];
    int            m_phase = 0;
    int            m_adc_cnt = 0;
    int            m_tail = 0;
    logic          m_wr_bank = 1'b0;
    logic          m_overrun = 1'b0;
    logic          m_done_exp = 1'b0;
    logic          m_prev_rdy = 1'b0;
    logic          m_q_valid = 1'b0;
    logic [DW-1:0] m_q_exp = '0;
    logic [DW-1:0] m_sum;
    bit            m_init = 0;

    always @(posedge clock) begin
        if (!reset) begin
            if (m_phase != 0)
                for (int a = 0; a < 512; a++) m_valid[m_wr_bank][a] = 0;
            m_q_exp    = '0;
            m_q_valid  = 1'b1;
            m_wr_bank  = 1'b0;
            m_overrun  = 1'b0;
            m_done_exp = 1'b0;
            m_phase    = 0;
            m_prev_rdy = 1'b0;
            m_init     = 1;
        end else begin
            m_q_valid  = m_valid[!m_wr_bank][rd_fdau];
            m_q_exp    = m_mem[!m_wr_bank][rd_fdau];
            m_done_exp = 1'b0;
            if (m_phase == 3) begin
                m_done_exp = 1'b1;
                m_sum = '0;
                for (int i = 0; i < FRAME_LEN; i++) begin
                    if (i >= N_ADC + N_CNT)
                        m_img[i] = digi_val((i - N_ADC - N_CNT) / DEPTH, (i - N_ADC - N_CNT) % DEPTH);
                    m_sum = m_sum + m_img[i];
                    m_mem[m_wr_bank][i]   = m_img[i];
                    m_valid[m_wr_bank][i] = 1;
                end
`ifdef FDAU_FRAME_CRC_EN
                m_mem[m_wr_bank][FRAME_LEN]   = m_sum;
                m_valid[m_wr_bank][FRAME_LEN] = 1;
`endif
                m_wr_bank = !m_wr_bank;
            end
            if (sec) begin
                if (m_phase == 1 || m_phase == 2)
                    m_overrun = 1'b1;
                m_phase   = 1;
                m_adc_cnt = 0;
            end else begin
                case (m_phase)
                    1: if (sample_rdy && !m_prev_rdy) begin
                        m_img[m_adc_cnt] = ADC_sample;
                        m_adc_cnt++;
                        if (m_adc_cnt == N_ADC) begin
                            m_phase = 2;
                            m_tail  = TAIL;
                        end
                    end
                    2: begin
                        if (TAIL - m_tail < N_CNT)
                            m_img[N_ADC + TAIL - m_tail] = cnt_words[(TAIL - m_tail)*DW +: DW];
                        m_tail--;
                        if (m_tail == 0)
                            m_phase = 3;
                    end
                    3: m_phase = 0;
                    default: ;
                endcase
            end
            m_prev_rdy = sample_rdy;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_init) begin
            if (frame_done)
                done_count++;
            checkOutput("model_rd_bank", 32'(rd_bank), 32'(!m_wr_bank));
            checkOutput("model_frame_done", 32'(frame_done), 32'(m_done_exp));
            checkOutput("model_overrun", 32'(overrun), 32'(m_overrun));
            if (m_q_valid)
                checkOutput("model_q_fdau", 32'(q_fdau), 32'(m_q_exp));
        end
    end

    task automatic applyStimulus(input logic s, input logic r, input logic [DW-1:0] d, input int n);
        sec        = s;
        sample_rdy = r;
        ADC_sample = d;
        @(negedge clock);
        sec = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic sendSample(input logic [DW-1:0] d);
        applyStimulus(1'b0, 1'b1, d, 1);
        applyStimulus(1'b0, 1'b0, d, 1);
    endtask

    task automatic sendFrame(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++)
            sendSample(base + 16'(i));
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!frame_done && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, 32'(frame_done), 32'd1);
    endtask

    task automatic readCheck(input string name, input int addr, input logic [DW-1:0] expected);
        rd_fdau = AW'(addr);
        @(negedge clock);
        checkOutput(name, 32'(q_fdau), 32'(expected));
    endtask

    initial begin
        int dc;
        reset      = 1'b0;
        sec        = 1'b0;
        sample_rdy = 1'b0;
        ADC_sample = '0;
        rd_fdau    = '0;
        // Word 1 (taho2) carries 0xCCCC so that address 66 holds it.
        cnt_words  = {16'hBBBB, 16'hCCCC, 16'hAAAA};
        repeat (3) @(negedge clock);
        checkOutput("reset_rd_bank", 32'(rd_bank), 32'd1);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset_q_fdau", 32'(q_fdau), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        $display("[TB] basic frame");
        applyStimulus(1'b1, 1'b0, '0, 1);
        sendFrame(16'h0000, N_ADC);
        waitDone("f1_done");
        checkOutput("f1_rd_bank", 32'(rd_bank), 32'd0);
        readCheck("f1_addr0", 0, 16'h0000);
        readCheck("f1_addr64", 64, 16'h0040);
        readCheck("f1_addr65", 65, 16'hAAAA);
        readCheck("f1_addr66", 66, 16'hCCCC);
        readCheck("f1_addr67", 67, 16'hBBBB);
        readCheck("f1_addr68", 68, 16'h0000);
        readCheck("f1_addr105", 68 + 32 + 5, 16'h0105);
        readCheck("f1_addr259", 259, 16'h051F);
        checkOutput("f1_done_count", 32'(done_count), 32'd1);

        $display("[TB] held sample_rdy, back-to-back frame");
        rd_fdau = '0;
        applyStimulus(1'b1, 1'b0, '0, 1);
        applyStimulus(1'b0, 1'b1, 16'h1234, 10);
        applyStimulus(1'b0, 1'b0, '0, 1);
        sendFrame(16'h2001, N_ADC - 1);
        checkOutput("f2_midframe_q", 32'(q_fdau), 32'h0000);
        checkOutput("f2_midframe_rd_bank", 32'(rd_bank), 32'd0);
        waitDone("f2_done");
        checkOutput("f2_rd_bank", 32'(rd_bank), 32'd1);
        readCheck("f2_addr0", 0, 16'h1234);
        readCheck("f2_addr1", 1, 16'h2001);
        readCheck("f2_addr64", 64, 16'h2040);

        $display("[TB] overrun restart");
        applyStimulus(1'b1, 1'b0, '0, 1);
        sendFrame(16'h7000, 20);
        checkOutput("f3_overrun_before", 32'(overrun), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, 1);
        checkOutput("f3_overrun_set", 32'(overrun), 32'd1);
        checkOutput("f3_rd_bank_kept", 32'(rd_bank), 32'd1);
        sendFrame(16'h3000, N_ADC);
        waitDone("f3_done");
        checkOutput("f3_rd_bank", 32'(rd_bank), 32'd0);
        readCheck("f3_addr0", 0, 16'h3000);
        readCheck("f3_addr19", 19, 16'h3013);
        readCheck("f3_addr20", 20, 16'h3014);
        checkOutput("f3_overrun_sticky", 32'(overrun), 32'd1);

        $display("[TB] reset mid-frame");
        dc = done_count;
        applyStimulus(1'b1, 1'b0, '0, 1);
        sendFrame(16'h6000, 10);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 2);
        reset = 1'b1;
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_rd_bank", 32'(rd_bank), 32'd1);
        applyStimulus(1'b0, 1'b0, '0, 20);
        checkOutput("rst_no_done", 32'(done_count), 32'(dc));

        $display("[TB] sec during FINISH");
        applyStimulus(1'b1, 1'b0, '0, 1);
        sendFrame(16'h4000, N_ADC);
        repeat (TAIL - 1) @(negedge clock);
        applyStimulus(1'b1, 1'b0, '0, 1);
        checkOutput("f5a_done", 32'(frame_done), 32'd1);
        checkOutput("f5a_rd_bank", 32'(rd_bank), 32'd0);
        sendFrame(16'h5000, N_ADC);
        waitDone("f5b_done");
        checkOutput("f5b_rd_bank", 32'(rd_bank), 32'd1);
        checkOutput("f5b_overrun", 32'(overrun), 32'd0);
        readCheck("f5b_addr0", 0, 16'h5000);
        readCheck("f5b_addr64", 64, 16'h5040);

        $display("[TB] all-ones frame");
        digi_mode = 1;
        cnt_words = {3{16'h0001}};
        applyStimulus(1'b1, 1'b0, '0, 1);
        for (int i = 0; i < N_ADC; i++)
            sendSample(16'h0001);
        waitDone("f6_done");
        checkOutput("f6_rd_bank", 32'(rd_bank), 32'd0);
        readCheck("f6_addr100", 100, 16'h0001);
        readCheck("f6_addr259", 259, 16'h0001);
`ifdef FDAU_FRAME_CRC_EN
        readCheck("f6_crc", 260, 16'h0104);
`endif
        applyStimulus(1'b0, 1'b0, '0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
